// File: rtl/spi_cmd_pkg.sv
// Shared types and sizing helpers for the SPI command slave.
// SPI_CMD_PARITY_EN adds one even-parity bit after the data field.
package spi_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_PAR,
      ST_DONE
   } state_t;

`ifdef SPI_CMD_PARITY_EN
   localparam int unsigned PARITY_BITS = 1;
`else
   localparam int unsigned PARITY_BITS = 0;
`endif

   function automatic int unsigned frame_len(input int unsigned adr, input int unsigned data);
      return 1 + adr + data + PARITY_BITS;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned adr, input int unsigned data);
      return $clog2(frame_len(adr, data) + 1);
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser with registered rise/fall strobes.
// Strobes appear STAGES+1 clk after the pin changes.
module spi_edge_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_dly;
   logic              r_rise;
   logic              r_fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {STAGES{RST_VAL}};
         r_dly  <= RST_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_dly  <= r_sync[STAGES-1];
         r_rise <= r_sync[STAGES-1] & ~r_dly;
         r_fall <= ~r_sync[STAGES-1] & r_dly;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/spi_cmd_slave.sv
// Clk-domain SPI mode-0 command slave: {read, address, data} frames in, reply MSB-first out.
// Optional SPI_CMD_PARITY_EN appends an even-parity bit checked before accepting.
module spi_cmd_slave
   import spi_cmd_pkg::*;
#(
   parameter int unsigned ADR_WIDTH   = 3,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sck,
   input  logic                  sel,
   input  logic                  sdi,
   output logic                  sdo,
   input  logic [DATA_WIDTH-1:0] replyData,
   output logic [ADR_WIDTH-1:0]  replyAdr,
   output logic                  replyEn,
   output logic [DATA_WIDTH-1:0] commData,
   output logic [ADR_WIDTH-1:0]  commAdr,
   output logic                  commRead,
   output logic                  commValid,
   output logic                  frameErr
);

   localparam int unsigned RX_LEN = 1 + ADR_WIDTH + DATA_WIDTH;
   localparam int unsigned CW     = cnt_width(ADR_WIDTH, DATA_WIDTH);
   localparam int unsigned SETTLE = SYNC_STAGES + 2;
   localparam int unsigned SW     = $clog2(SETTLE + 1);

   logic w_sck_rise, w_sck_fall, w_sel_rise, w_sel_fall, w_sdi;
   logic [RX_LEN-1:0] w_rx_next;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [RX_LEN-1:0]     r_rx;
   logic [DATA_WIDTH-1:0] r_tx;
   logic                  r_read, r_first;
   logic                  r_armed, r_block;
   logic [SW-1:0]         r_settle;
   logic [SYNC_STAGES:0]  r_sdi_sync;
   logic                  r_sdo, r_reply_en, r_comm_read, r_comm_valid, r_frame_err;
   logic [ADR_WIDTH-1:0]  r_reply_adr, r_comm_adr;
   logic [DATA_WIDTH-1:0] r_comm_data;

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .rst(rst), .i_d(sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
   );

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sel_sync (
      .clk(clk), .rst(rst), .i_d(sel), .o_rise(w_sel_rise), .o_fall(w_sel_fall)
   );

   // One extra stage so sdi lines up with the registered sck strobes
   always_ff @(posedge clk) begin
      if (rst) r_sdi_sync <= '0;
      else     r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-1:0], sdi};
   end

   assign w_sdi     = r_sdi_sync[SYNC_STAGES];
   assign w_rx_next = {r_rx[RX_LEN-2:0], w_sdi};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_rx         <= '0;
         r_tx         <= '0;
         r_read       <= 1'b0;
         r_first      <= 1'b0;
         r_armed      <= 1'b0;
         r_block      <= 1'b0;
         r_settle     <= '0;
         r_sdo        <= 1'b0;
         r_reply_en   <= 1'b0;
         r_reply_adr  <= '0;
         r_comm_data  <= '0;
         r_comm_adr   <= '0;
         r_comm_read  <= 1'b0;
         r_comm_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_comm_valid <= 1'b0;
         r_frame_err  <= 1'b0;

         // A sel already low at reset release shows up as a fall while settling; wait for a rise then
         if (r_settle != SW'(SETTLE)) begin
            r_settle <= r_settle + SW'(1);
            if (w_sel_fall) r_block <= 1'b1;
         end else if (w_sel_rise || !r_block) begin
            r_armed <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               r_sdo      <= 1'b0;
               r_reply_en <= 1'b0;
               if (w_sel_fall && r_armed) begin
                  r_state <= ST_HDR;
                  r_cnt   <= '0;
               end
            end

            ST_HDR: begin
               if (w_sel_rise) begin
                  r_frame_err <= 1'b1;
                  r_reply_en  <= 1'b0;
                  r_sdo       <= 1'b0;
                  r_state     <= ST_IDLE;
               end else if (w_sck_rise) begin
                  r_rx  <= w_rx_next;
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == CW'(ADR_WIDTH)) begin
                     r_reply_adr <= w_rx_next[ADR_WIDTH-1:0];
                     r_reply_en  <= w_rx_next[ADR_WIDTH];
                     r_read      <= w_rx_next[ADR_WIDTH];
                     r_first     <= 1'b1;
                     r_state     <= ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               if (w_sel_rise) begin
                  r_frame_err <= 1'b1;
                  r_reply_en  <= 1'b0;
                  r_sdo       <= 1'b0;
                  r_state     <= ST_IDLE;
               end else begin
                  if (r_first) begin
                     r_first <= 1'b0;
                     if (r_read) r_tx <= replyData;
                  end else if (w_sck_fall) begin
                     r_sdo <= r_read & r_tx[DATA_WIDTH-1];
                     r_tx  <= r_tx << 1;
                  end
                  if (w_sck_rise) begin
                     r_rx  <= w_rx_next;
                     r_cnt <= r_cnt + CW'(1);
                     if (r_cnt == CW'(RX_LEN - 1)) begin
`ifdef SPI_CMD_PARITY_EN
                        r_state <= ST_PAR;
`else
                        r_comm_valid <= 1'b1;
                        r_comm_data  <= w_rx_next[DATA_WIDTH-1:0];
                        r_comm_adr   <= w_rx_next[DATA_WIDTH +: ADR_WIDTH];
                        r_comm_read  <= w_rx_next[RX_LEN-1];
                        r_state      <= ST_DONE;
`endif
                     end
                  end
               end
            end

`ifdef SPI_CMD_PARITY_EN
            ST_PAR: begin
               r_sdo <= 1'b0;
               if (w_sel_rise) begin
                  r_frame_err <= 1'b1;
                  r_reply_en  <= 1'b0;
                  r_state     <= ST_IDLE;
               end else if (w_sck_rise) begin
                  // Even parity: the whole frame including the parity bit XORs to zero
                  if (^{r_rx, w_sdi}) begin
                     r_frame_err <= 1'b1;
                  end else begin
                     r_comm_valid <= 1'b1;
                     r_comm_data  <= r_rx[DATA_WIDTH-1:0];
                     r_comm_adr   <= r_rx[DATA_WIDTH +: ADR_WIDTH];
                     r_comm_read  <= r_rx[RX_LEN-1];
                  end
                  r_state <= ST_DONE;
               end
            end
`endif

            ST_DONE: begin
               r_sdo <= 1'b0;
               if (w_sel_rise) begin
                  r_reply_en <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sdo       = r_sdo;
   assign replyEn   = r_reply_en;
   assign replyAdr  = r_reply_adr;
   assign commData  = r_comm_data;
   assign commAdr   = r_comm_adr;
   assign commRead  = r_comm_read;
   assign commValid = r_comm_valid;
   assign frameErr  = r_frame_err;

endmodule
